// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the two-requester multiplier scheduler.
package mul_sched_pkg;

   localparam int NREQ = 2;

   typedef enum {SLOT_EMPTY, SLOT_FULL} slot_state_t;

   typedef logic req_id_t;

   // Index of the set bit in a two-way one-hot grant (0 when idle).
   function automatic req_id_t gnt2id(input logic [NREQ-1:0] g);
      return g[1];
   endfunction

endpackage

// File: rtl/mul_scheduler_rr_arb2.sv
// Two-way round-robin grant; the pointer moves past the winner only on advance.
module rr_arb2
   import mul_sched_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   input  logic            advance,
   output logic [NREQ-1:0] gnt
);

   req_id_t prio;

   always_comb begin
      gnt = '0;
      if (enable) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         prio <= 1'b0;
      else if (advance)
         prio <= ~gnt2id(gnt);
   end

endmodule

// File: rtl/multiplicador.sv
// Combinational signed n x n -> 2n multiplier; car mirrors the product sign.
module multiplicador #(
   parameter int n = 5
) (
   input  logic signed [n-1:0]   a,
   input  logic signed [n-1:0]   b,
   output logic signed [2*n-1:0] p,
   output logic                  car
);

   logic signed [2*n-1:0] ax, bx;

   assign ax  = {{n{a[n-1]}}, a};
   assign bx  = {{n{b[n-1]}}, b};
   assign p   = ax * bx;
   assign car = p[2*n-1];

endmodule

// File: rtl/mul_scheduler.sv
// Shares one signed multiplier between two requesters behind a single result slot.
// Optional MUL_SCHED_OVF_STICKY_EN adds a clearable sticky overflow flag.
module mul_scheduler
   import mul_sched_pkg::*;
#(
   parameter int N         = 5,
   parameter int OVF_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*N-1:0]    req_a,
   input  logic [NREQ*N-1:0]    req_b,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [2*N-1:0]       res_data,
   output logic                 res_ovf,
   output logic                 res_id,
   output logic [OVF_CNT_W-1:0] ovf_count,
   output logic                 ovf_sticky,
   input  logic                 ovf_clr
);

   localparam logic [0:0] S_EMPTY = 1'(SLOT_EMPTY);
   localparam logic [0:0] S_FULL  = 1'(SLOT_FULL);

   typedef struct packed {
      logic [2*N-1:0] data;
      logic           ovf;
      req_id_t        id;
   } res_t;

   logic [NREQ-1:0][N-1:0] op_a, op_b;
   logic [NREQ-1:0]        gnt;
   logic [0:0]             state;
   logic                   can_accept, accept, ovf;
   req_id_t                gid;
   logic signed [N-1:0]    mul_a, mul_b;
   logic signed [2*N-1:0]  prod;
   logic [N:0]             prod_hi;
   res_t                   slot;

   assign op_a       = req_a;
   assign op_b       = req_b;
   assign can_accept = (state == S_EMPTY) | res_ready;
   assign accept     = |gnt;
   assign gid        = gnt2id(gnt);
   assign req_ready  = gnt;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .enable  (can_accept),
      .advance (accept),
      .gnt     (gnt)
   );

   assign mul_a = op_a[gid];
   assign mul_b = op_b[gid];

   multiplicador #(.n(N)) u_mul (
      .a   (mul_a),
      .b   (mul_b),
      .p   (prod),
      .car ()
   );

   // Fits in N-bit signed only if the top N+1 bits are pure sign extension.
   assign prod_hi = prod[2*N-1:N-1];
   assign ovf     = !((&prod_hi) | (~|prod_hi));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_EMPTY;
         slot      <= '0;
         ovf_count <= '0;
      end else begin
         if (accept) begin
            state <= S_FULL;
            slot  <= '{data: prod, ovf: ovf, id: gid};
         end else if (res_ready) begin
            state <= S_EMPTY;
         end
         if (accept && ovf && !(&ovf_count))
            ovf_count <= ovf_count + OVF_CNT_W'(1);
      end
   end

   assign res_valid = (state == S_FULL);
   assign res_data  = slot.data;
   assign res_ovf   = slot.ovf;
   assign res_id    = slot.id;

`ifdef MUL_SCHED_OVF_STICKY_EN
   // Set wins over clear when both land on the same edge.
   always_ff @(posedge clk) begin
      if (rst)
         ovf_sticky <= 1'b0;
      else if (accept && ovf)
         ovf_sticky <= 1'b1;
      else if (ovf_clr)
         ovf_sticky <= 1'b0;
   end
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_mul_scheduler.sv
// Scoreboard bench for mul_scheduler: driver pushes expected results, monitor pops on handshake.
module tb_mul_scheduler;

   localparam int N = 5;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [1:0]     req_valid = '0;
   logic [1:0]     req_ready;
   logic [2*N-1:0] req_a = '0, req_b = '0;
   logic           res_valid;
   logic           res_ready = 1'b1;
   logic [2*N-1:0] res_data;
   logic           res_ovf, res_id;
   logic [W-1:0]   ovf_count;
   logic           ovf_sticky;
   logic           ovf_clr = 1'b0;

   always #5 clk = ~clk;

   mul_scheduler #(.N(N), .OVF_CNT_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_ovf    (res_ovf),
      .res_id     (res_id),
      .ovf_count  (ovf_count),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr)
   );

   typedef struct {
      logic [2*N-1:0] d;
      logic           o;
      logic           id;
      logic [W-1:0]   c;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int tests = 0;
   int fails = 0;

   // requester-side state and arbiter/slot reference model
   logic [1:0]     rv = '0;
   logic [N-1:0]   ra[2], rb[2];
   logic [2*N-1:0] ed[2];
   logic           eo[2];
   logic           mfull = 1'b0;
   logic           mprio = 1'b0;
   logic [W-1:0]   mcnt = '0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] d, input logic o);
      rv[i] = 1'b1;
      ra[i] = a;
      rb[i] = b;
      ed[i] = d;
      eo[i] = o;
   endtask

   task automatic step();
      logic [1:0] mg;
      logic       can;
      int         g;
      mg        = '0;
      req_valid = rv;
      req_a     = {ra[1], ra[0]};
      req_b     = {rb[1], rb[0]};
      @(negedge clk);
      if (!rst) begin
         can = !mfull || res_ready;
         if (can) mg = (rv == 2'b11) ? (mprio ? 2'b10 : 2'b01) : rv;
         chk("req_ready", 32'(req_ready), 32'(mg));
         if (mg != 2'b00) begin
            g = mg[1] ? 1 : 0;
            if (eo[g] && mcnt != '1) mcnt = mcnt + 1'b1;
            q.push_back('{ed[g], eo[g], mg[1], mcnt});
            mprio = ~mg[1];
         end
         mfull = (mg != 2'b00) || (mfull && !res_ready);
      end
      @(posedge clk);
      #1;
      if (!rst) rv = rv & ~mg;
   endtask

   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got data %0h expected no result", res_data);
         end else begin
            me = q.pop_front();
            chk("res_data", 32'(res_data), 32'(me.d));
            chk("res_ovf", 32'(res_ovf), 32'(me.o));
            chk("res_id", 32'(res_id), 32'(me.id));
            chk("ovf_count", 32'(ovf_count), 32'(me.c));
         end
      end
   end

   logic [N-1:0]   ta[5] = '{5'h10, 5'h0F, 5'h10, 5'h04, 5'h00};
   logic [N-1:0]   tb_[5] = '{5'h0F, 5'h0F, 5'h01, 5'h04, 5'h10};
   logic [2*N-1:0] td[5] = '{10'h310, 10'h0E1, 10'h3F0, 10'h010, 10'h000};
   logic           to[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      ra = '{default: '0}; rb = '{default: '0};
      ed = '{default: '0}; eo = '{default: 1'b0};
      step();
      step();
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_data", 32'(res_data), 0);
      chk("rst_res_ovf", 32'(res_ovf), 0);
      chk("rst_res_id", 32'(res_id), 0);
      chk("rst_ovf_count", 32'(ovf_count), 0);
      chk("rst_ovf_sticky", 32'(ovf_sticky), 0);
      rst = 1'b0;

      // basic products
      set_req(0, 5'd3, 5'h1C, 10'h3F4, 1'b0);
      step();
      chk("t1_valid", 32'(res_valid), 1);
      chk("t1_data", 32'(res_data), 32'h3F4);
      set_req(1, 5'd7, 5'd5, 10'h023, 1'b1);
      step();
      set_req(1, 5'h10, 5'h10, 10'h100, 1'b1);
      step();
      chk("t2_data", 32'(res_data), 32'h100);
      step();
      chk("t2_ovf_count", 32'(ovf_count), 2);
      chk("t2_empty", 32'(res_valid), 0);

      // both requesting: alternation 0,1,0,1
      for (int k = 0; k < 4; k++) begin
         set_req(0, 5'd2, 5'd3, 10'h006, 1'b0);
         set_req(1, 5'h1D, 5'd5, 10'h3F1, 1'b0);
         step();
         chk("alt_id", 32'(res_id), 32'(k % 2));
      end
      rv = '0;
      step();

      // boundary operands
      for (int k = 0; k < 5; k++) begin
         set_req(0, ta[k], tb_[k], td[k], to[k]);
         step();
      end
      step();

      // backpressure: slot held, then no-bubble refill
      res_ready = 1'b0;
      set_req(0, 5'h10, 5'h01, 10'h3F0, 1'b0);
      step();
      set_req(0, 5'h1F, 5'h1F, 10'h001, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_valid", 32'(res_valid), 1);
         chk("hold_data", 32'(res_data), 32'h3F0);
      end
      res_ready = 1'b1;
      step();
      chk("refill_valid", 32'(res_valid), 1);
      chk("refill_data", 32'(res_data), 32'h001);
      step();

      // sticky overflow
`ifdef MUL_SCHED_OVF_STICKY_EN
      ovf_clr = 1'b1;
      set_req(0, 5'd7, 5'd5, 10'h023, 1'b1);
      step();
      chk("sticky_set_wins", 32'(ovf_sticky), 1);
      step();
      chk("sticky_clr", 32'(ovf_sticky), 0);
      ovf_clr = 1'b0;
`else
      set_req(0, 5'd7, 5'd5, 10'h023, 1'b1);
      step();
      chk("sticky_tied", 32'(ovf_sticky), 0);
`endif
      step();

      // reset while full with both requesters waiting
      res_ready = 1'b0;
      set_req(0, 5'd1, 5'd1, 10'h001, 1'b0);
      step();
      set_req(0, 5'd2, 5'd2, 10'h004, 1'b0);
      set_req(1, 5'd3, 5'd3, 10'h009, 1'b0);
      step();
      rst = 1'b1;
      step();
      chk("rst2_valid", 32'(res_valid), 0);
      chk("rst2_ovf_count", 32'(ovf_count), 0);
      chk("rst2_data", 32'(res_data), 0);
      q.delete();
      mfull = 1'b0; mprio = 1'b0; mcnt = '0;
      rst = 1'b0;
      res_ready = 1'b1;
      step();
      chk("rst2_first_id", 32'(res_id), 0);
      step();
      step();

      // counter saturation
      for (int k = 0; k < 260; k++) begin
         set_req(0, 5'd7, 5'd5, 10'h023, 1'b1);
         step();
      end
      step();
      chk("sat_ovf_count", 32'(ovf_count), 32'hFF);
      step();
      chk("queue_empty", 32'(q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
